// File: rtl/thread_cmd_queue.sv
// thread_cmd_queue: FIFO of CPU thread commands (RUN/STOP) issued to the threads
// manager in controller issue slots, with timed retry on rejection and a drop
// after too many rejections.
// Optional build feature: define TCQ_STATS_EN to add the saturating acc_cnt and
// drop_cnt statistics outputs.

`ifndef CTL_CPU_CMD
`define CTL_CPU_CMD 8'h03
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef THREAD_CMD_RUN
`define THREAD_CMD_RUN 4'h1
`endif
`ifndef THREAD_CMD_STOP
`define THREAD_CMD_STOP 4'h2
`endif

module thread_cmd_queue #(
  parameter int DEPTH     = 4,
  parameter int RETRY_GAP = 4,
  parameter int MAX_RETRY = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_oe,
  input  logic [7:0]            ctl_state,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_cmd,
  input  logic [`DATA_SIZE-1:0] req_data,
  input  logic [`ADDR_SIZE-1:0] req_addr,
  output logic [3:0]            thrd_cmd,
  output logic [`DATA_SIZE-1:0] data_out,
  output logic [`ADDR_SIZE-1:0] addr_out,
  input  logic [1:0]            thrd_rslt,
  output logic                  drop_pulse,
  output logic                  busy
`ifdef TCQ_STATS_EN
  ,
  output logic [15:0]           acc_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int GW = (RETRY_GAP < 1) ? 1 : $clog2(RETRY_GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_BACKOFF
  } state_t;

  typedef struct packed {
    logic [3:0]            cmd;
    logic [`DATA_SIZE-1:0] data;
    logic [`ADDR_SIZE-1:0] addr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  state_t          state, state_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic [GW-1:0]   gap, gap_nxt;
  logic            pop, drop_nxt, accepted;
  logic            cmd_ok, handshake, push, issue_fire;
  entry_t          head;

  assign req_ready  = (count < CW'(DEPTH));
  assign cmd_ok     = (req_cmd == `THREAD_CMD_RUN) || (req_cmd == `THREAD_CMD_STOP);
  // Unsupported commands still complete the handshake; they are just not stored.
  assign handshake  = req_valid && req_ready;
  assign push       = handshake && cmd_ok;
  assign head       = mem[rd_ptr];
  assign busy       = (count != '0) || (state != S_IDLE);

  // The issue strobe is qualified by the enable and reset so a frozen or
  // resetting cycle never shows a command to the manager.
  assign issue_fire = clk_oe && rst && (state == S_ISSUE) && (ctl_state == `CTL_CPU_CMD);
  assign thrd_cmd   = issue_fire ? head.cmd  : 4'h0;
  assign data_out   = issue_fire ? head.data : '0;
  assign addr_out   = issue_fire ? head.addr : '0;

  // Next-state logic: issue, wait for the result, retry after a gap or drop.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    state_nxt = state;
    retry_nxt = retry;
    gap_nxt   = gap;
    pop       = 1'b0;
    drop_nxt  = 1'b0;
    accepted  = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (ctl_state == `CTL_CPU_CMD) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Only result 1 means accepted; every other code is treated as a rejection.
        if (thrd_rslt == 2'd1) begin
          pop       = 1'b1;
          accepted  = 1'b1;
          retry_nxt = '0;
          state_nxt = (count > CW'(1)) ? S_ISSUE : S_IDLE;
        end else if (retry == RW'(MAX_RETRY)) begin
          // This rejection would push the count past the limit: drop the head.
          pop       = 1'b1;
          drop_nxt  = 1'b1;
          retry_nxt = '0;
          state_nxt = S_IDLE;
        end else begin
          retry_nxt = retry + RW'(1);
          gap_nxt   = GW'(RETRY_GAP);
          state_nxt = S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        // Leaving when the counter hits zero puts RETRY_GAP backoff cycles
        // between the result cycle and the re-issue cycle.
        if (gap <= GW'(1)) begin
          gap_nxt   = '0;
          state_nxt = S_ISSUE;
        end else begin
          gap_nxt = gap - GW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers: pointers, occupancy, FSM, retry/gap counters, drop strobe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (clk_oe) begin
      if (!rst) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        state      <= S_IDLE;
        retry      <= '0;
        gap        <= '0;
        drop_pulse <= 1'b0;
      end else begin
        state      <= state_nxt;
        retry      <= retry_nxt;
        gap        <= gap_nxt;
        drop_pulse <= drop_nxt;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers and count alone
    // decide which entries are meaningful.
    if (clk_oe && rst && push) mem[wr_ptr] <= '{cmd: req_cmd, data: req_data, addr: req_addr};
  end

`ifdef TCQ_STATS_EN
  // Saturating counters of accepted and dropped commands.
  always_ff @(posedge clk) begin
    if (clk_oe) begin
      if (!rst) begin
        acc_cnt  <= '0;
        drop_cnt <= '0;
      end else begin
        if (accepted && (acc_cnt != 16'hFFFF))  acc_cnt  <= acc_cnt + 16'd1;
        if (drop_nxt && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_thread_cmd_queue.sv
// Scoreboard bench for thread_cmd_queue: stimulus queues the expected issues,
// responses and drop strobes; a negedge monitor compares what the DUT presents.

`ifndef CTL_CPU_CMD
`define CTL_CPU_CMD 8'h03
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef THREAD_CMD_RUN
`define THREAD_CMD_RUN 4'h1
`endif
`ifndef THREAD_CMD_STOP
`define THREAD_CMD_STOP 4'h2
`endif

module tb_thread_cmd_queue;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clk_oe;
  logic [7:0]            ctl_state;
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_cmd;
  logic [`DATA_SIZE-1:0] req_data;
  logic [`ADDR_SIZE-1:0] req_addr;
  logic [3:0]            thrd_cmd;
  logic [`DATA_SIZE-1:0] data_out;
  logic [`ADDR_SIZE-1:0] addr_out;
  logic [1:0]            thrd_rslt;
  logic                  drop_pulse;
  logic                  busy;
`ifdef TCQ_STATS_EN
  logic [15:0]           acc_cnt;
  logic [15:0]           drop_cnt;
`endif

  thread_cmd_queue #(.DEPTH(4), .RETRY_GAP(4), .MAX_RETRY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_oe     (clk_oe),
    .ctl_state  (ctl_state),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_data   (req_data),
    .req_addr   (req_addr),
    .thrd_cmd   (thrd_cmd),
    .data_out   (data_out),
    .addr_out   (addr_out),
    .thrd_rslt  (thrd_rslt),
    .drop_pulse (drop_pulse),
    .busy       (busy)
`ifdef TCQ_STATS_EN
    ,
    .acc_cnt    (acc_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]            cmd;
    logic [`DATA_SIZE-1:0] data;
    logic [`ADDR_SIZE-1:0] addr;
    int                    gap;   // cycles since previous issue; 0 = don't care
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] resp_q[$];
  int         drop_q[$];          // expected cycles from last issue to drop strobe
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_issue = 0;
  int         issue_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [3:0] c, input logic [`DATA_SIZE-1:0] d,
                              input logic [`ADDR_SIZE-1:0] a, input int g, input logic [1:0] r);
    exp_t e;
    e.cmd = c; e.data = d; e.addr = a; e.gap = g;
    exp_q.push_back(e);
    resp_q.push_back(r);
  endtask

  task automatic push(input logic [3:0] c, input logic [`DATA_SIZE-1:0] d, input logic [`ADDR_SIZE-1:0] a);
    req_valid = 1'b1; req_cmd = c; req_data = d; req_addr = a;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n);
    int k;
    k = 0;
    while (issue_cnt < n && k < 60) begin
      step(1);
      k++;
    end
    check("issue_wait_timeout", issue_cnt >= n, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && k < 200) begin
      step(1);
      k++;
    end
    check("idle_wait_timeout", (busy === 1'b0) && (exp_q.size() == 0), 1);
  endtask

  // Monitor: compare issues and drop strobes; answer each issue with the queued result.
  initial begin
    exp_t e;
    int   d;
    thrd_rslt = 2'd0;
    forever begin
      @(negedge clk);
      if (drop_pulse === 1'b1) begin
        check("drop_expected", drop_q.size() != 0, 1);
        if (drop_q.size() != 0) begin
          d = drop_q.pop_front();
          check("drop_delay", cyc - last_issue, d);
        end
      end
      if (thrd_cmd !== 4'h0) begin
        issue_cnt++;
        check("issue_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("issue_cmd", thrd_cmd, e.cmd);
          check("issue_data", data_out, e.data);
          check("issue_addr", addr_out, e.addr);
          if (e.gap != 0) check("issue_gap", cyc - last_issue, e.gap);
        end
        last_issue = cyc;
        thrd_rslt = (resp_q.size() != 0) ? resp_q.pop_front() : 2'd1;
      end else begin
        check("idle_bus_zero", {data_out, addr_out}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  // Directed stimulus.
  initial begin
    int base;
    rst = 1'b0; clk_oe = 1'b1; ctl_state = 8'h00;
    req_valid = 1'b0; req_cmd = 4'h0; req_data = '0; req_addr = '0;
    step(2);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_thrd_cmd", thrd_cmd, 0);
    check("rst_drop", drop_pulse, 0);
    rst = 1'b1;
    step(1);

    // Single RUN accept; busy clears two cycles after the issue cycle.
    ctl_state = `CTL_CPU_CMD;
    base = issue_cnt;
    expect_issue(`THREAD_CMD_RUN, 32'd5, 16'h0040, 0, 2'd1);
    push(`THREAD_CMD_RUN, 32'd5, 16'h0040);
    wait_issues(base + 1);
    check("busy_in_wait", busy, 1);
    step(1);
    check("busy_after_accept", busy, 0);

    // Unsupported command is swallowed: nothing queued, nothing issued.
    push(4'h7, 32'hDEAD, 16'h0BAD);
    step(3);
    check("bad_cmd_not_queued", busy, 0);
    check("bad_cmd_ready", req_ready, 1);

    // One rejection then accept: re-issue 6 cycles after the first issue.
    expect_issue(`THREAD_CMD_STOP, 32'hA, 16'h0044, 0, 2'd0);
    expect_issue(`THREAD_CMD_STOP, 32'hA, 16'h0044, 6, 2'd1);
    push(`THREAD_CMD_STOP, 32'hA, 16'h0044);
    wait_idle();

    // Three rejections with MAX_RETRY=2: drop, then the next entry issues.
    expect_issue(`THREAD_CMD_RUN, 32'h11, 16'h0050, 0, 2'd0);
    expect_issue(`THREAD_CMD_RUN, 32'h11, 16'h0050, 6, 2'd0);
    expect_issue(`THREAD_CMD_RUN, 32'h11, 16'h0050, 6, 2'd0);
    expect_issue(`THREAD_CMD_RUN, 32'h22, 16'h0054, 3, 2'd1);
    drop_q.push_back(2);
    push(`THREAD_CMD_RUN, 32'h11, 16'h0050);
    push(`THREAD_CMD_RUN, 32'h22, 16'h0054);
    wait_idle();
    check("drop_seen", drop_q.size(), 0);

    // Fill with no issue slots: fifth request refused, order preserved.
    ctl_state = 8'h00;
    for (int i = 1; i <= 4; i++) begin
      expect_issue((i % 2) ? `THREAD_CMD_RUN : `THREAD_CMD_STOP, 32'(i), 16'(16'h0060 + i),
                   (i == 1) ? 0 : 2, 2'd1);
      push((i % 2) ? `THREAD_CMD_RUN : `THREAD_CMD_STOP, 32'(i), 16'(16'h0060 + i));
    end
    check("full_not_ready", req_ready, 0);
    req_valid = 1'b1; req_cmd = `THREAD_CMD_RUN; req_data = 32'd5; req_addr = 16'h0065;
    #2;
    check("fifth_refused", req_ready, 0);
    step(1);
    req_valid = 1'b0;
    step(2);
    check("full_still_busy", busy, 1);
    ctl_state = `CTL_CPU_CMD;
    wait_idle();

    // Freeze for 3 cycles in BACKOFF: re-issue moves from 6 to 9 cycles.
    base = issue_cnt;
    expect_issue(`THREAD_CMD_RUN, 32'h33, 16'h0070, 0, 2'd0);
    expect_issue(`THREAD_CMD_RUN, 32'h33, 16'h0070, 9, 2'd1);
    push(`THREAD_CMD_RUN, 32'h33, 16'h0070);
    wait_issues(base + 1);
    step(2);
    clk_oe = 1'b0;
    step(3);
    clk_oe = 1'b1;
    wait_idle();

    // Reset during WAIT with two entries: everything discarded, no drop.
    base = issue_cnt;
    expect_issue(`THREAD_CMD_STOP, 32'h44, 16'h0080, 0, 2'd1);
    push(`THREAD_CMD_STOP, 32'h44, 16'h0080);
    push(`THREAD_CMD_RUN, 32'h55, 16'h0084);
    wait_issues(base + 1);
    check("busy_before_reset", busy, 1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_ready", req_ready, 1);
    step(10);
    check("reset_stays_idle", busy, 0);
    check("reset_no_issue", issue_cnt, base + 1);

    check("exp_queue_empty", exp_q.size(), 0);
    check("drop_queue_empty", drop_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thread_cmd_queue.md
THREAD_CMD_QUEUE -- requirements
Module: thread_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RETRY_GAP, default 4, meaning cycles waited after a rejected command before re-issue.
REQ-003 SHALL have parameter MAX_RETRY, default 15, meaning rejections tolerated before the head entry is dropped.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port clk_oe, input, 1 bit: clock enable; 0 freezes all state.
REQ-007 SHALL have port ctl_state, input, 8 bits: controller state; an issue slot exists when it equals `CTL_CPU_CMD.
REQ-008 SHALL have ports req_valid (input, 1 bit), req_ready (output, 1 bit), req_cmd (input, 4 bits), req_data (input, `DATA_SIZE bits) and req_addr (input, `ADDR_SIZE bits): the CPU-side request.
REQ-009 SHALL have ports thrd_cmd (output, 4 bits), data_out (output, `DATA_SIZE bits) and addr_out (output, `ADDR_SIZE bits): the command to the threads manager.
REQ-010 SHALL have port thrd_rslt, input, 2 bits: manager result; 1 = accepted, 0 = rejected.
REQ-011 SHALL have ports drop_pulse (output, 1 bit) and busy (output, 1 bit): drop strobe and non-empty-or-active flag.

Function
REQ-012 SHALL accept only req_cmd values `THREAD_CMD_RUN and `THREAD_CMD_STOP.
  - Any other value with req_valid=1 is consumed and discarded without being enqueued.
REQ-013 SHALL set req_ready=1 when count<DEPTH.
  - count is taken from the registered value.
  - A push and a pop in the same cycle when full are not allowed: the push is refused.
REQ-014 SHALL enqueue {req_cmd, req_data, req_addr} on a cycle where req_valid=1, req_ready=1 and clk_oe=1.
  - Queue order is FIFO.
  - Read and write pointers wrap modulo DEPTH.
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and BACKOFF.
REQ-016 SHALL perform IDLE->ISSUE when count>0.
REQ-017 SHALL, in ISSUE, drive the head entry on thrd_cmd, data_out and addr_out, and go to WAIT, on the first cycle where ctl_state==`CTL_CPU_CMD.
  - thrd_cmd is driven for exactly one cycle.
  - At all other times thrd_cmd=4'h0 and data_out=addr_out=0.
REQ-018 SHALL, in WAIT, sample thrd_rslt on the cycle following the issue cycle (one-cycle result latency).
REQ-019 SHALL, on a WAIT result of 1, pop the head, clear the retry count and go to IDLE.
  - When count>1 the FSM goes directly to ISSUE instead.
REQ-020 SHALL, on a WAIT result of 0, increment the retry count, load the gap counter with RETRY_GAP and go to BACKOFF.
REQ-021 SHALL, on a rejection that makes the retry count exceed MAX_RETRY, pop the head, pulse drop_pulse for one cycle, clear the retry count and go to IDLE.
REQ-022 SHALL, in BACKOFF, decrement the gap counter each enabled cycle and go to ISSUE when it reaches 0.
REQ-023 SHALL size the retry counter as clog2(MAX_RETRY+1) bits and SHALL never let it wrap.
REQ-024 SHALL drive busy = (count!=0) or (state!=IDLE).
REQ-025 SHALL hold all registers when clk_oe=0, including the gap counter; a frozen result cycle extends WAIT.

Reset
REQ-026 SHALL, on rst=0 at a clk edge with clk_oe=1, clear the pointers, count, retry count and gap counter, set the FSM to IDLE, drive thrd_cmd=0, data_out=0, addr_out=0 and drop_pulse=0, and set req_ready=1 from the next cycle.
REQ-027 SHALL, on reset mid-operation (during WAIT or BACKOFF), discard the in-flight command with no drop_pulse.

Configuration
REQ-028 SHALL, with TCQ_STATS_EN defined, add outputs acc_cnt and drop_cnt (16 bits each, saturating, reset to 0) that count accepted and dropped commands.
REQ-029 SHALL, without TCQ_STATS_EN, omit those ports and counters entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover a single RUN accept: push RUN data=5 addr=0x40, hold ctl_state=`CTL_CPU_CMD, thrd_rslt=1 after the issue cycle -> thrd_cmd=RUN for one cycle, head popped, busy=0 two cycles later.
REQ-031 SHALL cover retry: one rejection then an accept with RETRY_GAP=4 -> the second issue occurs exactly 5 cycles after the rejection is sampled, and the same data and address are re-sent.
REQ-032 SHALL cover drop: MAX_RETRY=2 with 3 consecutive rejections -> drop_pulse=1 for one cycle, and the next entry is issued.
REQ-033 SHALL cover fill: push 5 requests with DEPTH=4 and no issue slots -> req_ready=0 after the 4th, the 5th is not accepted, and later issue order is 1..4.
REQ-034 SHALL cover a freeze: clk_oe=0 for 3 cycles during BACKOFF -> re-issue is delayed by exactly 3 cycles.
REQ-035 SHALL cover reset mid-operation: rst=0 during WAIT with 2 entries queued -> count=0, FSM in IDLE, no issue and no drop_pulse afterwards.
